// File: rtl/ddr_rd_pkg.sv
// Shared types and widths for the DDR read-capture block.
package ddr_rd_pkg;
    localparam int LEN_W = 3;
    localparam int LAT_W = 3;
    localparam int CNT_W = (LEN_W > LAT_W) ? LEN_W : LAT_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } rd_state_t;
endpackage

// File: rtl/ddr_rd_fifo.sv
// Synchronous word queue; a push into a full queue is accepted only when a pop frees a slot the same cycle.
module ddr_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ddr_rd_capture.sv
// DDR read-burst capture: waits out CAS latency, samples {q1,q0} per beat and queues the words.
//   state      | meaning
//   ST_IDLE    | no burst; accepts rd_start
//   ST_WAIT    | counting down CAS latency
//   ST_CAPTURE | sampling one word per cycle until burst length reached
module ddr_rd_capture
    import ddr_rd_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rd_start,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic [LAT_W-1:0]  cas_lat,
    input  logic [DW-1:0]     q0,
    input  logic [DW-1:0]     q1,
    output logic              dq_ce,
    output logic [2*DW-1:0]   rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    input  logic              clr_err
);
    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_drop;
    logic             capture;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done    <= (state_q == ST_CAPTURE) && (state_d == ST_IDLE);
            // A drop in the same cycle as clr_err must leave the flag set.
            if (fifo_drop)    overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    len_d = rd_len;
                    if (cas_lat == '0) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = CNT_W'(rd_len);
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(cas_lat - 1'b1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = CNT_W'(len_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign dq_ce    = busy;
    assign capture  = (state_q == ST_CAPTURE);
    assign rd_valid = ~fifo_empty;

    ddr_rd_fifo #(
        .WIDTH (2*DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (capture),
        .push_data ({q1, q0}),
        .pop       (rd_ready),
        .head      (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );
endmodule
